mult_rr_sched: RTL
==================

Name: mult_rr_sched

Overview:
- Round-robin scheduler that shares one signed multiplier datapath between NREQ requesters.
- Each cycle it picks at most one requester and steers that requester's operands to the multiplier.
- It asserts the multiplier's enable and tracks an ID tag through the multiplier latency, so each product returns with the originating requester ID.
- It sits between the multiply-hungry clients (filters, correlators) and a single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- AW, 16, operand A width (signed).
- BW, 16, operand B width (signed).
- LAT, 1, multiplier latency in cycles, en-to-out (1..8).
- IDW (localparam), $clog2(NREQ), requester ID width.
- OW (localparam), AW+BW, product width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with operands stable until granted.
- a_in  in  NREQ*AW  packed operand A; requester i occupies bits [i*AW +: AW].
- b_in  in  NREQ*BW  packed operand B; requester i occupies bits [i*BW +: BW].
- gnt  out  NREQ  one-hot grant, combinational, valid in the cycle its operands are consumed.
- flush  in  1  stop granting and drain in-flight operations.
- mul_en  out  1  multiplier enable.
- mul_a  out  AW  operand A to the multiplier.
- mul_b  out  BW  operand B to the multiplier.
- mul_out  in  OW  multiplier product.
- res_valid  out  1  product valid.
- res_id  out  IDW  requester ID of the product.
- res_data  out  OW  product; equals mul_out.
- busy  out  1  at least one operation in flight, or the FSM is in DRAIN.

Behaviour:
- Reset:
  - rst high at a clock edge: res_valid=0, res_id=0, busy=0, rr pointer=0, tag pipe cleared, FSM=IDLE.
  - gnt, mul_en, mul_a and mul_b are 0 while rst is high.
- Arbitration:
  - Search req starting at pointer ptr, wrapping NREQ-1 -> 0; the first set bit wins.
  - On a grant to requester k, ptr <= (k+1) mod NREQ. With no grant, ptr holds.
  - At most one grant per cycle; back-to-back grants to different requesters are allowed, giving throughput of 1 per cycle.
- Datapath steering:
  - mul_a and mul_b are combinational muxes of the granted slice; mul_en = |gnt.
  - With no grant, mul_a=0 and mul_b=0, so the multiplier outputs 0.
- Tag pipe:
  - LAT-stage shift register of {valid, id}. Stage 0 loads {|gnt, k}.
  - res_valid and res_id are taken from stage LAT-1 registered, so a product appears exactly LAT cycles after its gnt.
  - res_data = mul_out unmodified (full OW bits, no truncation).
- FSM:
  - IDLE: no grant has been issued and the pipe is empty. Any req with flush low -> RUN, granting in that same cycle.
  - RUN: grants as above. flush high -> DRAIN with no grant that cycle. Pipe empty and req==0 -> IDLE.
  - DRAIN: gnt=0. When the pipe is empty and flush is low -> IDLE. While flush stays high, remain in DRAIN.
- Boundary cases:
  - req and flush in the same cycle: flush wins and no grant is issued.
  - A single requester continuously requesting is granted every cycle.
  - All requesters requesting are served in strict rotation 0,1,2,3,0...
  - req dropped before grant: no result is produced.
  - Reset mid-operation: in-flight products are discarded; res_valid stays 0 even though mul_out may still change.

Optional Feature:
- Macro: MULT_RR_SCHED_GNT_CNT_EN.
- Defined: adds output gnt_cnt (NREQ*16 bits), a per-requester saturating 16-bit grant counter.
  - Cleared by rst.
  - Increments on each grant.
  - Holds at 0xFFFF.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mult_pkg holds:
  - default widths MULT_AW=16 and MULT_BW=16;
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - the tag struct {valid, id}.
- Sub-module rr_arbiter (req, ptr -> one-hot gnt, winner index) is natural and reusable. The FSM, tag pipe and steering stay in the top.

Test Plan:
- Reset: rst=1 for 3 cycles with req=4'b1111 -> gnt=0, mul_en=0, res_valid=0 throughout. First grant after release goes to requester 0.
- Single request: LAT=1, req=4'b0100, a=3, b=-5 -> gnt=4'b0100 that cycle; next cycle res_valid=1, res_id=2, res_data=-15.
- Full contention: req=4'b1111 held for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; products return in the same order, each tagged with the correct ID.
- Pipelined multiplier: LAT=3, 5 back-to-back grants -> res_valid high for exactly 5 cycles starting 3 cycles after the first gnt; then busy falls.
- Flush: assert flush with 2 operations in flight -> gnt=0 immediately; both results still delivered; FSM returns to IDLE only after flush drops and the pipe is empty.
- Extremes: a=-32768, b=-32768 -> res_data=0x40000000. With MULT_RR_SCHED_GNT_CNT_EN defined, 70000 grants to requester 1 -> gnt_cnt slice for requester 1 reads 0xFFFF.

Source files
------------

// File: rtl/mult_rr_sched_pkg.sv
// Shared widths, FSM encoding and tag layout for the
// round-robin multiplier scheduler.
package mult_pkg;

    localparam int MULT_AW      = 16;
    localparam int MULT_BW      = 16;
    // Widest requester ID supported (NREQ up to 16).
    localparam int MULT_IDW_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                    valid;
        logic [MULT_IDW_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_rr_sched_arb.sv
// Round-robin arbiter: first set request at or after
// the pointer wins, wrapping past the top index.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [IDW:0] pos;

    // Rotating priority search starting at ptr_i.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, ptr_i} + (IDW+1)'(i);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            if (!any_o && req_i[pos[IDW-1:0]]) begin
                any_o                = 1'b1;
                idx_o                = pos[IDW-1:0];
                gnt_o[pos[IDW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Shares one signed multiplier among NREQ requesters.
// Optional MULT_RR_SCHED_GNT_CNT_EN adds saturating grant counters.
module mult_rr_sched
    import mult_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int AW   = MULT_AW,
    parameter  int BW   = MULT_BW,
    parameter  int LAT  = 1,
    localparam int IDW  = $clog2(NREQ),
    localparam int OW   = AW + BW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] a_in,
    input  logic [NREQ*BW-1:0] b_in,
    output logic [NREQ-1:0]  gnt,
    input  logic             flush,
    output logic             mul_en,
    output logic [AW-1:0]    mul_a,
    output logic [BW-1:0]    mul_b,
    input  logic [OW-1:0]    mul_out,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [OW-1:0]    res_data,
    output logic             busy
`ifdef MULT_RR_SCHED_GNT_CNT_EN
    ,
    output logic [NREQ*16-1:0] gnt_cnt
`endif
);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    tag_t            tag_q [LAT];
    tag_t            tag_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;
    logic            grant_ok;
    logic            gnt_any;
    logic            pipe_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Grant gating and operand steering toward the multiplier.
    always_comb begin
        grant_ok = !rst && !flush && (state_q != DRAIN);
        gnt_any  = grant_ok && arb_any;
        gnt      = grant_ok ? arb_gnt : '0;
        mul_en   = gnt_any;
        mul_a    = gnt_any ? a_in[arb_idx*AW +: AW] : '0;
        mul_b    = gnt_any ? b_in[arb_idx*BW +: BW] : '0;
        ptr_d    = ptr_q;
        if (gnt_any) begin
            ptr_d = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
        end
        tag_d.valid = gnt_any;
        tag_d.id    = gnt_any ? MULT_IDW_MAX'(arb_idx) : '0;
    end

    // Any operation still travelling through the multiplier.
    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            pipe_any = pipe_any | tag_q[i].valid;
        end
    end

    // Tag shift register tracking requester IDs through the latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Scheduler FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            unique case (state_q)
                IDLE: begin
                    if (!flush && (|req)) state_q <= RUN;
                end
                RUN: begin
                    if (flush) state_q <= DRAIN;
                    else if (!pipe_any && (req == '0)) state_q <= IDLE;
                end
                DRAIN: begin
                    if (!pipe_any && !flush) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = tag_q[LAT-1].valid;
    assign res_id    = tag_q[LAT-1].id[IDW-1:0];
    assign res_data  = mul_out;
    assign busy      = pipe_any || (state_q == DRAIN);

`ifdef MULT_RR_SCHED_GNT_CNT_EN
    logic [15:0] cnt_q [NREQ];

    // Per-requester grant counters that stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (gnt[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    // Pack the counters onto the output bus.
    always_comb begin
        gnt_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    // No grant counters in this build.
`endif

endmodule
